// File: rtl/trap_sequencer_if.sv
// Writeback-side trap/MRET event bundle and the sequencer's redirect/CSR-write responses.
// master: pipeline/CSR side that raises events; slave: trap_sequencer.
interface trap_sequencer_if;
    logic        WB_V;
    logic [63:0] WB_PC;
    logic [63:0] WB_NPC;
    logic [31:0] WB_IR;
    logic        WB_MRET;
    logic        WB_ECALL;
    logic        F_IAM;
    logic        F_IAF;
    logic        F_II;
    logic        MEM_LAM;
    logic        MEM_LAF;
    logic        MEM_SAM;
    logic        MEM_SAF;
    logic [63:0] BAD_ADDR;
    logic        TIMER;
    logic        EXTERNAL;
    logic [63:0] MSTATUS_IN;
    logic [63:0] MIE_IN;
    logic [63:0] MTVEC_IN;
    logic [63:0] MEPC_IN;
    logic        TS_KILL;
    logic        TS_BUSY;
    logic        TS_CSR_WE;
    logic [11:0] TS_CSR_ADDR;
    logic [63:0] TS_CSR_WDATA;
    logic        TS_PC_MUX;
    logic [63:0] TS_PC_TARGET;
    logic        TS_PRIV;

    modport master (
        output WB_V, WB_PC, WB_NPC, WB_IR, WB_MRET, WB_ECALL,
        output F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, BAD_ADDR,
        output TIMER, EXTERNAL, MSTATUS_IN, MIE_IN, MTVEC_IN, MEPC_IN,
        input  TS_KILL, TS_BUSY, TS_CSR_WE, TS_CSR_ADDR, TS_CSR_WDATA,
        input  TS_PC_MUX, TS_PC_TARGET, TS_PRIV
    );

    modport slave (
        input  WB_V, WB_PC, WB_NPC, WB_IR, WB_MRET, WB_ECALL,
        input  F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, BAD_ADDR,
        input  TIMER, EXTERNAL, MSTATUS_IN, MIE_IN, MTVEC_IN, MEPC_IN,
        output TS_KILL, TS_BUSY, TS_CSR_WE, TS_CSR_ADDR, TS_CSR_WDATA,
        output TS_PC_MUX, TS_PC_TARGET, TS_PRIV
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: serialises mepc/mcause/mtval/mstatus writes, then redirects fetch.
// Optional macro VECTORED_MTVEC_EN: interrupts use base + 4*cause when mtvec mode is vectored.
module trap_sequencer #(
    parameter logic        RESET_PRIV  = 1'b1,
    parameter int unsigned IRQ_HOLDOFF = 2
) (
    input logic             CLK,
    input logic             RESET,
    trap_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_EPC, S_CAUSE, S_TVAL, S_STATUS, S_RSTAT, S_REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic        priv_q, priv_d;
    logic [3:0]  holdoff_q, holdoff_d;
    logic        is_mret_q, is_mret_d;
    logic        is_irq_q, is_irq_d;
    logic [63:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d;

    logic        exc_sel;
    logic [63:0] exc_cause, exc_tval;
    logic        irq_ok, ext_take, tim_take;
    logic [63:0] ms_trap, ms_mret, trap_base, trap_tgt;
    logic        kill, csr_we, pc_mux;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, pc_tgt;
    logic        unused_bits;

    // Exception priority: first match wins.
    always_comb begin
        exc_sel   = 1'b1;
        exc_cause = 64'd0;
        exc_tval  = 64'd0;
        if (bus.F_IAF) begin
            exc_cause = 64'd1; exc_tval = bus.BAD_ADDR;
        end else if (bus.F_IAM) begin
            exc_cause = 64'd0; exc_tval = bus.BAD_ADDR;
        end else if (bus.F_II) begin
            exc_cause = 64'd2; exc_tval = {32'b0, bus.WB_IR};
        end else if (bus.WB_ECALL) begin
            exc_cause = priv_q ? 64'd11 : 64'd8;
        end else if (bus.MEM_SAM) begin
            exc_cause = 64'd6; exc_tval = bus.BAD_ADDR;
        end else if (bus.MEM_LAM) begin
            exc_cause = 64'd4; exc_tval = bus.BAD_ADDR;
        end else if (bus.MEM_SAF) begin
            exc_cause = 64'd7; exc_tval = bus.BAD_ADDR;
        end else if (bus.MEM_LAF) begin
            exc_cause = 64'd5; exc_tval = bus.BAD_ADDR;
        end else begin
            exc_sel = 1'b0;
        end
    end

    assign irq_ok   = bus.MSTATUS_IN[3] && (holdoff_q == 4'd0);
    assign ext_take = irq_ok && bus.EXTERNAL && bus.MIE_IN[11];
    assign tim_take = irq_ok && bus.TIMER && bus.MIE_IN[7];

    always_comb begin
        ms_trap          = bus.MSTATUS_IN;
        ms_trap[7]       = bus.MSTATUS_IN[3];
        ms_trap[3]       = 1'b0;
        ms_trap[12:11]   = {2{priv_q}};
        ms_mret          = bus.MSTATUS_IN;
        ms_mret[3]       = bus.MSTATUS_IN[7];
        ms_mret[7]       = 1'b1;
        ms_mret[12:11]   = 2'b00;
    end

    assign trap_base = {bus.MTVEC_IN[63:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
    assign trap_tgt = (is_irq_q && bus.MTVEC_IN[1:0] == 2'b01)
                    ? trap_base + {56'b0, cause_q[5:0], 2'b00} : trap_base;
`else
    assign trap_tgt = trap_base;
`endif

    always_comb begin
        state_d   = state_q;
        priv_d    = priv_q;
        holdoff_d = holdoff_q;
        is_mret_d = is_mret_q;
        is_irq_d  = is_irq_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        kill      = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = 64'd0;
        pc_mux    = 1'b0;
        pc_tgt    = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (holdoff_q != 4'd0) holdoff_d = holdoff_q - 4'd1;
                if (bus.WB_V) begin
                    if (exc_sel) begin
                        kill = 1'b1; state_d = S_EPC; is_mret_d = 1'b0; is_irq_d = 1'b0;
                        epc_d = bus.WB_PC; cause_d = exc_cause; tval_d = exc_tval;
                    end else if (bus.WB_MRET) begin
                        state_d = S_RSTAT; is_mret_d = 1'b1; is_irq_d = 1'b0;
                    end else if (ext_take || tim_take) begin
                        // Interrupt: WB instruction retires, so resume after it.
                        state_d = S_EPC; is_mret_d = 1'b0; is_irq_d = 1'b1;
                        epc_d = bus.WB_NPC; tval_d = 64'd0;
                        cause_d = ext_take ? {1'b1, 63'd11} : {1'b1, 63'd7};
                    end
                end
            end
            S_EPC: begin
                csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = epc_q; state_d = S_CAUSE;
            end
            S_CAUSE: begin
                csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = cause_q; state_d = S_TVAL;
            end
            S_TVAL: begin
                csr_we = 1'b1; csr_addr = 12'h343; csr_wdata = tval_q; state_d = S_STATUS;
            end
            S_STATUS: begin
                csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = ms_trap;
                priv_d = 1'b1; state_d = S_REDIRECT;
            end
            S_RSTAT: begin
                csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = ms_mret;
                priv_d = (bus.MSTATUS_IN[12:11] != 2'b00); state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                pc_mux    = 1'b1;
                pc_tgt    = is_mret_q ? bus.MEPC_IN : trap_tgt;
                holdoff_d = 4'(IRQ_HOLDOFF);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            priv_q    <= RESET_PRIV;
            holdoff_q <= 4'd0;
            is_mret_q <= 1'b0;
            is_irq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            priv_q    <= priv_d;
            holdoff_q <= holdoff_d;
            is_mret_q <= is_mret_d;
            is_irq_q  <= is_irq_d;
        end
    end

    always_ff @(posedge CLK) begin
        epc_q   <= epc_d;
        cause_q <= cause_d;
        tval_q  <= tval_d;
    end

    assign bus.TS_KILL      = kill & ~RESET;
    assign bus.TS_BUSY      = (state_q != S_IDLE);
    assign bus.TS_CSR_WE    = csr_we;
    assign bus.TS_CSR_ADDR  = csr_addr;
    assign bus.TS_CSR_WDATA = csr_wdata;
    assign bus.TS_PC_MUX    = pc_mux;
    assign bus.TS_PC_TARGET = pc_tgt;
    assign bus.TS_PRIV      = priv_q;

    assign unused_bits = ^{bus.MIE_IN[63:12], bus.MIE_IN[10:8], bus.MIE_IN[6:0], bus.MTVEC_IN[1:0]};
endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized bench for trap_sequencer against a transaction-level model of trap/MRET sequencing.
module tb_trap_sequencer;
    localparam int unsigned IRQ_HOLDOFF = 2;
    localparam logic        RESET_PRIV  = 1'b1;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    trap_sequencer_if bus ();

    trap_sequencer #(.RESET_PRIV(RESET_PRIV), .IRQ_HOLDOFF(IRQ_HOLDOFF)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic        v, mret, ecall, iam, iaf, ii, lam, laf, sam, saf, timer, ext;
        logic [63:0] pc, npc, bad, mstatus, mie, mtvec, mepc;
        logic [31:0] ir;
    } tx_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic priv_m;
    int   hold_m;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic tx_t zero_tx();
        tx_t t;
        {t.v, t.mret, t.ecall, t.iam, t.iaf, t.ii, t.lam, t.laf, t.sam, t.saf, t.timer, t.ext} = '0;
        t.pc = 0; t.npc = 0; t.bad = 0; t.mstatus = 0; t.mie = 0; t.mtvec = 0; t.mepc = 0; t.ir = 0;
        return t;
    endfunction

    function automatic tx_t rand_tx();
        tx_t t = zero_tx();
        t.v     = ($urandom_range(7) != 0);
        t.pc    = {$urandom(), $urandom()} & ~64'h3;
        t.npc   = t.pc + 64'd4;
        t.ir    = $urandom();
        t.iaf   = ($urandom_range(11) == 0);
        t.iam   = ($urandom_range(11) == 0);
        t.ii    = ($urandom_range(11) == 0);
        t.ecall = ($urandom_range(11) == 0);
        t.sam   = ($urandom_range(11) == 0);
        t.lam   = ($urandom_range(11) == 0);
        t.saf   = ($urandom_range(11) == 0);
        t.laf   = ($urandom_range(11) == 0);
        t.mret  = ($urandom_range(3) == 0);
        t.timer = ($urandom_range(2) == 0);
        t.ext   = ($urandom_range(2) == 0);
        t.bad   = {$urandom(), $urandom()};
        t.mstatus = {$urandom(), $urandom()};
        if ($urandom_range(3) != 0) t.mstatus[3] = 1'b1;
        t.mie[7]  = ($urandom_range(3) != 0);
        t.mie[11] = ($urandom_range(3) != 0);
        t.mtvec = {$urandom(), $urandom()};
        t.mepc  = {$urandom(), $urandom()};
        return t;
    endfunction

    // Busy-cycle stimulus: random events, CSR views held steady.
    function automatic tx_t scramble(input tx_t t);
        tx_t r = rand_tx();
        r.mstatus = t.mstatus; r.mie = t.mie; r.mtvec = t.mtvec; r.mepc = t.mepc;
        return r;
    endfunction

    task automatic drive(input tx_t t);
        bus.WB_V = t.v; bus.WB_PC = t.pc; bus.WB_NPC = t.npc; bus.WB_IR = t.ir;
        bus.WB_MRET = t.mret; bus.WB_ECALL = t.ecall;
        bus.F_IAM = t.iam; bus.F_IAF = t.iaf; bus.F_II = t.ii;
        bus.MEM_LAM = t.lam; bus.MEM_LAF = t.laf; bus.MEM_SAM = t.sam; bus.MEM_SAF = t.saf;
        bus.BAD_ADDR = t.bad; bus.TIMER = t.timer; bus.EXTERNAL = t.ext;
        bus.MSTATUS_IN = t.mstatus; bus.MIE_IN = t.mie; bus.MTVEC_IN = t.mtvec; bus.MEPC_IN = t.mepc;
    endtask

    // kind: 0 nothing, 1 exception, 2 MRET, 3 interrupt
    function automatic void predict(input tx_t t, output int kind, output logic [63:0] cause,
                                    output logic [63:0] epc, output logic [63:0] tval);
        logic [7:0]  f;
        logic [63:0] c [8];
        f = {t.laf, t.saf, t.lam, t.sam, t.ecall, t.ii, t.iam, t.iaf};
        c = '{64'd1, 64'd0, 64'd2, (priv_m ? 64'd11 : 64'd8), 64'd6, 64'd4, 64'd7, 64'd5};
        kind = 0; cause = 0; epc = 0; tval = 0;
        if (!t.v) return;
        for (int i = 0; i < 8; i++) begin
            if (f[i]) begin
                kind = 1; cause = c[i]; epc = t.pc;
                tval = (i == 2) ? {32'b0, t.ir} : ((i == 3) ? 64'd0 : t.bad);
                return;
            end
        end
        if (t.mret) begin kind = 2; return; end
        if (t.mstatus[3] && hold_m == 0) begin
            if (t.ext && t.mie[11]) begin kind = 3; cause = {1'b1, 63'd11}; epc = t.npc; return; end
            if (t.timer && t.mie[7]) begin kind = 3; cause = {1'b1, 63'd7}; epc = t.npc; return; end
        end
    endfunction

    // Called right after a falling edge with the DUT idle; returns after a falling edge.
    task automatic run_txn(input tx_t t);
        int kind, len;
        logic [63:0] cause, epc, tval, msw, tgt;
        logic npriv;
        logic [11:0] a [4];
        logic [63:0] d [4];
        predict(t, kind, cause, epc, tval);
        drive(t);
        #1;
        check_val("kill", {63'b0, bus.TS_KILL}, {63'b0, kind == 1});
        check_val("busy_idle", {63'b0, bus.TS_BUSY}, 64'd0);
        check_val("pcmux_idle", {63'b0, bus.TS_PC_MUX}, 64'd0);
        check_val("we_idle", {63'b0, bus.TS_CSR_WE}, 64'd0);
        check_val("priv", {63'b0, bus.TS_PRIV}, {63'b0, priv_m});
        @(posedge CLK);
        if (kind == 0) begin
            if (hold_m > 0) hold_m--;
            @(negedge CLK);
            return;
        end
        msw = t.mstatus;
        tgt = {t.mtvec[63:2], 2'b00};
        if (kind == 2) begin
            msw[3] = t.mstatus[7]; msw[7] = 1'b1; msw[12:11] = 2'b00;
            npriv = (t.mstatus[12:11] != 2'b00);
            len = 2; a[0] = 12'h300; d[0] = msw; tgt = t.mepc;
        end else begin
            msw[7] = t.mstatus[3]; msw[3] = 1'b0; msw[12:11] = priv_m ? 2'b11 : 2'b00;
            npriv = 1'b1; len = 5;
            a[0] = 12'h341; d[0] = epc;
            a[1] = 12'h342; d[1] = cause;
            a[2] = 12'h343; d[2] = tval;
            a[3] = 12'h300; d[3] = msw;
`ifdef VECTORED_MTVEC_EN
            if (kind == 3 && t.mtvec[1:0] == 2'b01) tgt = tgt + {56'b0, cause[5:0], 2'b00};
`endif
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge CLK);
            drive(scramble(t));
            #1;
            check_val("busy", {63'b0, bus.TS_BUSY}, 64'd1);
            check_val("csr_we", {63'b0, bus.TS_CSR_WE}, {63'b0, k < len});
            check_val("pc_mux", {63'b0, bus.TS_PC_MUX}, {63'b0, k == len});
            if (k < len) begin
                check_val("csr_addr", {52'b0, bus.TS_CSR_ADDR}, {52'b0, a[k-1]});
                check_val("csr_wdata", bus.TS_CSR_WDATA, d[k-1]);
            end else begin
                check_val("pc_target", bus.TS_PC_TARGET, tgt);
            end
            @(posedge CLK);
        end
        priv_m = npriv;
        hold_m = IRQ_HOLDOFF;
        @(negedge CLK);
    endtask

    tx_t t;

    initial begin
        RESET = 1'b1;
        drive(zero_tx());
        priv_m = RESET_PRIV;
        hold_m = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        check_val("rst_busy", {63'b0, bus.TS_BUSY}, 64'd0);
        check_val("rst_we", {63'b0, bus.TS_CSR_WE}, 64'd0);
        check_val("rst_pcmux", {63'b0, bus.TS_PC_MUX}, 64'd0);
        check_val("rst_target", bus.TS_PC_TARGET, 64'd0);
        check_val("rst_wdata", bus.TS_CSR_WDATA, 64'd0);
        check_val("rst_priv", {63'b0, bus.TS_PRIV}, {63'b0, RESET_PRIV});
        RESET = 1'b0;
        @(negedge CLK);

        // Illegal instruction
        t = zero_tx(); t.v = 1; t.ii = 1; t.ir = 32'hFFFF_FFFF; t.pc = 64'h1000; t.npc = 64'h1004;
        t.mtvec = 64'h8000; t.mstatus = 64'h8;
        run_txn(t);
        // IAF beats LAM
        t = zero_tx(); t.v = 1; t.iaf = 1; t.lam = 1; t.bad = 64'h23; t.pc = 64'h1100; t.mtvec = 64'h8000;
        run_txn(t);
        // MRET into U-mode
        t = zero_tx(); t.v = 1; t.mret = 1; t.mstatus = 64'h80; t.mepc = 64'h3000;
        run_txn(t);
        // ECALL from U with external pending
        t = zero_tx(); t.v = 1; t.ecall = 1; t.ext = 1; t.mie = 64'h800; t.mstatus = 64'h8;
        t.pc = 64'h3000; t.mtvec = 64'h8001;
        run_txn(t);
        t = zero_tx(); t.v = 1; t.mret = 1; t.mstatus = 64'h80; t.mepc = 64'h3000;
        run_txn(t);
        // Timer held right after redirect: ignored during holdoff, then taken
        t = zero_tx(); t.v = 1; t.timer = 1; t.mie = 64'h80; t.mstatus = 64'h88;
        t.pc = 64'h2000; t.npc = 64'h2004; t.mtvec = 64'h8001;
        repeat (IRQ_HOLDOFF + 1) run_txn(t);

        for (int n = 0; n < 300; n++) run_txn(rand_tx());

        // Reset in the middle of a trap sequence
        t = zero_tx(); t.v = 1; t.ii = 1; t.pc = 64'h4000; t.mtvec = 64'h9000;
        drive(t);
        @(posedge CLK);
        @(negedge CLK);
        drive(zero_tx());
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check_val("cause_state_we", {63'b0, bus.TS_CSR_WE}, 64'd1);
        check_val("cause_state_addr", {52'b0, bus.TS_CSR_ADDR}, 64'h342);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        priv_m = RESET_PRIV;
        hold_m = 0;
        #1;
        check_val("midrst_busy", {63'b0, bus.TS_BUSY}, 64'd0);
        check_val("midrst_priv", {63'b0, bus.TS_PRIV}, {63'b0, RESET_PRIV});
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            #1;
            check_val("midrst_pcmux", {63'b0, bus.TS_PC_MUX}, 64'd0);
            check_val("midrst_idle", {63'b0, bus.TS_BUSY}, 64'd0);
        end
        @(negedge CLK);
        t = zero_tx(); t.v = 1; t.ecall = 1; t.pc = 64'h5000; t.mtvec = 64'hA000;
        run_txn(t);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
